// File: rtl/mips_seq_ctrl_if.sv
// Instruction-fetch handshake between the sequencing controller and instruction memory.
interface mips_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS sequencing controller: fetch/decode/exec/mul-wait/writeback
// with a fetch-ack timeout, sticky HALT/ERR and a retired-instruction counter.
module mips_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  mips_seq_ctrl_if.master       imem,
  output logic [31:0]           instr,
  output logic [1:0]            ALUop,
  output logic                  rf_we,
  output logic [4:0]            rf_wa,
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic [31:0]           retired
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MULW, WB, HALT, ERR
  } state_t;

  localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] ret_cnt;
  logic [7:0]  to_cnt;
  logic [3:0]  mul_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      ret_cnt <= '0;
      to_cnt  <= '0;
      mul_cnt <= '0;
    end else begin
      state <= state_n;
      if (state != FETCH && state_n == FETCH)
        to_cnt <= '0;
      else if (state == FETCH)
        to_cnt <= to_cnt + 8'd1;
      if (state == EXEC)
        mul_cnt <= '0;
      else if (state == MULW)
        mul_cnt <= mul_cnt + 4'd1;
      if (state == FETCH && imem.imem_ack)
        ir <= imem.imem_rdata;
      if (state == WB) begin
        pc      <= pc + 32'd4;
        ret_cnt <= ret_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (run) state_n = FETCH;
      FETCH:  if (imem.imem_ack)        state_n = DECODE;
              else if (to_cnt == TO_LAST) state_n = ERR;
      DECODE: state_n = (ir[31:26] == 6'h3F) ? HALT : EXEC;
      EXEC:   state_n = (ir[27:26] == 2'b10) ? MULW : WB;
      MULW:   if (mul_cnt == MUL_LAST) state_n = WB;
      WB:     state_n = run ? FETCH : IDLE;
      HALT:   state_n = HALT;
      ERR:    state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  // Control outputs are gated by RST so they read idle for the whole reset cycle.
  always_comb begin
    imem.imem_req  = !RST && (state == FETCH);
    imem.imem_addr = pc;
    instr          = ir;
    retired        = ret_cnt;
    rf_wa          = ir[15:11];
    ALUop          = 2'b00;
    if (!RST && (state == EXEC || state == MULW || state == WB))
      ALUop = ir[27:26];
    rf_we  = !RST && (state == WB) && ir[5] && (ir[15:11] != 5'd0);
    busy   = !RST && (state != IDLE) && (state != HALT) && (state != ERR);
    halted = !RST && (state == HALT);
    err    = !RST && (state == ERR);
  end

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Directed bench for mips_seq_ctrl: default instance plus a RESET_PC=FFFF_FFFC instance.
module tb_mips_seq_ctrl;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, run, RST1, run1;
  logic [31:0] instr, retired, instr1, retired1;
  logic [1:0]  ALUop, ALUop1;
  logic        rf_we, busy, halted, err, rf_we1, busy1, halted1, err1;
  logic [4:0]  rf_wa, rf_wa1;

  mips_seq_ctrl_if bus ();
  mips_seq_ctrl_if bus1 ();

  mips_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .run(run), .imem(bus.master),
    .instr(instr), .ALUop(ALUop), .rf_we(rf_we), .rf_wa(rf_wa),
    .busy(busy), .halted(halted), .err(err), .retired(retired)
  );

  mips_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .CLK(CLK), .RST(RST1), .run(run1), .imem(bus1.master),
    .instr(instr1), .ALUop(ALUop1), .rf_we(rf_we1), .rf_wa(rf_wa1),
    .busy(busy1), .halted(halted1), .err(err1), .retired(retired1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; run = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    RST1 = 1'b1; run1 = 1'b0; bus1.imem_ack = 1'b0; bus1.imem_rdata = '0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_req", bus.imem_req, 0);
    check("rst_retired", retired, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", bus.imem_addr, 32'h0);
    check("rst_aluop", ALUop, 0);

    // ALU instruction, ack on first FETCH cycle
    RST = 1'b0; run = 1'b1;
    step();
    check("alu_fetch_req", bus.imem_req, 1);
    check("alu_fetch_addr", bus.imem_addr, 32'h0);
    check("alu_fetch_busy", busy, 1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0820;
    step();
    bus.imem_ack = 1'b0;
    check("alu_dec_ir", instr, 32'h0000_0820);
    check("alu_dec_req", bus.imem_req, 0);
    step();
    check("alu_exec_we", rf_we, 0);
    step();
    check("alu_wb_we", rf_we, 1);
    check("alu_wb_wa", rf_wa, 5'd1);
    run = 1'b0;
    step();
    check("alu_idle_we", rf_we, 0);
    check("alu_retired", retired, 1);
    check("alu_pc", bus.imem_addr, 32'h4);
    check("alu_idle_busy", busy, 0);

    // Multiply instruction, MUL_CYCLES=4
    run = 1'b1;
    step();
    check("mul_fetch_addr", bus.imem_addr, 32'h4);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0800_0820;
    step();
    bus.imem_ack = 1'b0;
    check("mul_dec_aluop", ALUop, 2'b00);
    step();
    check("mul_exec_aluop", ALUop, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mulw%0d_aluop", i), ALUop, 2'b10);
      check($sformatf("mulw%0d_we", i), rf_we, 0);
      check($sformatf("mulw%0d_busy", i), busy, 1);
    end
    step();
    check("mul_wb_we", rf_we, 1);
    check("mul_wb_aluop", ALUop, 2'b10);
    run = 1'b0;
    step();
    check("mul_retired", retired, 2);
    check("mul_pc", bus.imem_addr, 32'h8);
    check("mul_idle_aluop", ALUop, 2'b00);

    // Reset asserted on the 2nd MULW cycle
    run = 1'b1;
    step();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0800_0820;
    step();
    bus.imem_ack = 1'b0;
    step(); step(); step();
    check("mrst_mulw2_busy", busy, 1);
    RST = 1'b1;
    #1;
    check("mrst_during_busy", busy, 0);
    check("mrst_during_we", rf_we, 0);
    check("mrst_during_aluop", ALUop, 0);
    step();
    RST = 1'b0; run = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_pc", bus.imem_addr, 32'h0);
    check("mrst_retired", retired, 0);
    check("mrst_ir", instr, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("mrst_idle%0d_we", i), rf_we, 0);
    end

    // HALT opcode
    run = 1'b1;
    step();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFC00_0000;
    step();
    bus.imem_ack = 1'b0;
    check("halt_dec_halted", halted, 0);
    step();
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_we", rf_we, 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0820;
    step(); step();
    bus.imem_ack = 1'b0;
    check("halt_sticky", halted, 1);
    check("halt_retired", retired, 0);
    check("halt_ir", instr, 32'hFC00_0000);
    check("halt_pc", bus.imem_addr, 32'h0);
    check("halt_req", bus.imem_req, 0);

    // Fetch-ack timeout
    RST = 1'b1;
    step();
    RST = 1'b0; run = 1'b1;
    #1;
    check("to_rst_halted", halted, 0);
    step();
    for (int i = 0; i < 254; i++) step();
    check("to_254_busy", busy, 1);
    check("to_254_req", bus.imem_req, 1);
    check("to_254_addr", bus.imem_addr, 32'h0);
    check("to_254_err", err, 0);
    step();
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_req", bus.imem_req, 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0820;
    step();
    bus.imem_ack = 1'b0;
    check("to_late_ack_err", err, 1);
    check("to_late_ack_ir", instr, 0);
    RST = 1'b1;
    step();
    RST = 1'b0; run = 1'b0;
    #1;
    check("to_clear_err", err, 0);
    check("to_clear_busy", busy, 0);

    // RESET_PC wrap and rd=0 write suppression on the second instance
    check("w_rst_pc", bus1.imem_addr, 32'hFFFF_FFFC);
    RST1 = 1'b0; run1 = 1'b1;
    step();
    check("w_fetch_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 32'h0000_0020;
    step();
    bus1.imem_ack = 1'b0;
    step(); step();
    check("w_wb_busy", busy1, 1);
    check("w_rd0_we", rf_we1, 0);
    run1 = 1'b0;
    step();
    check("w_pc_wrap", bus1.imem_addr, 32'h0);
    check("w_retired", retired1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mips_seq_ctrl.md
MIPS_SEQ_CTRL -- requirements
Module: mips_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL have parameter MUL_CYCLES, default 4 (legal 1..15), the number of MULW wait cycles for ALUop 2'b10.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255 (legal 1..255), the maximum FETCH cycles allowed without imem_ack.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port run, input, 1 bit: level-sensitive enable that allows leaving IDLE.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-008 SHALL have port imem_addr, output, 32 bits: fetch address, equal to PC.
REQ-009 SHALL have port imem_ack, input, 1 bit: fetch acknowledge; imem_rdata is valid in the same cycle.
REQ-010 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-011 SHALL have port instr, output, 32 bits: latched instruction register (IR) that drives the datapath decoder.
REQ-012 SHALL have port ALUop, output, 2 bits: ALU operation select.
REQ-013 SHALL have port rf_we, output, 1 bit: register-file write enable.
REQ-014 SHALL have port rf_wa, output, 5 bits: register-file write address.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE, HALT or ERR.
REQ-016 SHALL have ports halted and err, outputs, 1 bit each: status flags, high in HALT and ERR respectively.
REQ-017 SHALL have port retired, output, 32 bits: count of completed instructions.

Function
REQ-018 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MULW, WB, HALT and ERR, with exactly one state active per cycle.
REQ-019 SHALL move IDLE->FETCH on the cycle after run=1 is sampled, and SHALL remain in IDLE while run=0.
REQ-020 SHALL hold imem_req=1 and imem_addr=PC constant for every FETCH cycle, and SHALL hold imem_req=0 in every other state.
REQ-021 SHALL, on a FETCH cycle with imem_ack=1, latch imem_rdata into IR and move to DECODE; a late ack in any non-FETCH state SHALL be ignored.
REQ-022 SHALL count consecutive FETCH cycles without ack and move to ERR when the count reaches ACK_TIMEOUT; the counter SHALL clear on entry to FETCH.
REQ-023 SHALL, in DECODE, move to HALT if IR[31:26]=6'b111111, and otherwise move to EXEC.
REQ-024 SHALL drive ALUop=IR[27:26] in EXEC, MULW and WB, and ALUop=2'b00 in all other states.
REQ-025 SHALL, in EXEC, move to MULW if ALUop=2'b10, and otherwise move to WB.
REQ-026 SHALL stay in MULW for exactly MUL_CYCLES cycles, then move to WB.
REQ-027 SHALL assert rf_we for exactly one cycle in WB, only when IR[5]=1 and IR[15:11]!=0.
REQ-028 SHALL drive rf_wa=IR[15:11] at all times.
REQ-029 SHALL, in WB, set PC=PC+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) and increment retired, wrapping modulo 2^32.
REQ-030 SHALL, leaving WB, go to FETCH if run=1, or to IDLE if run=0.
REQ-031 SHALL keep run=0 from aborting an instruction already in progress; it takes effect only at the WB exit.
REQ-032 SHALL give a non-multiply instruction a latency of FETCH(n) + DECODE + EXEC + WB = n+3 cycles, and a multiply instruction n+3+MUL_CYCLES cycles.
REQ-033 SHALL make HALT and ERR sticky: only RST exits them, and PC, IR and retired SHALL hold their values.

Reset
REQ-034 SHALL, when RST=1 at a rising edge and regardless of state (including mid-FETCH or mid-MULW), set state=IDLE, PC=RESET_PC, IR=0, retired=0 and the timeout counter to 0.
REQ-035 SHALL, during reset, drive the outputs to imem_req=0, rf_we=0, ALUop=0, busy=0, halted=0 and err=0.
REQ-036 SHALL give RST priority over run and imem_ack in the same cycle.

Verification
REQ-037 SHALL be tested with: run=1; ack on the 1st FETCH cycle; IR=32'h0000_0820 (op 0, rd=1, IR[5]=1) -> rf_we high 3 cycles after ack, retired=1, PC=4.
REQ-038 SHALL be tested with: IR=32'h0800_0820 (op=2, MUL) and MUL_CYCLES=4 -> MULW lasts 4 cycles, rf_we appears 7 cycles after ack, ALUop=2'b10 throughout EXEC, MULW and WB.
REQ-039 SHALL be tested with: ack withheld for 255 cycles -> err=1 and busy=0; a later ack is ignored; RST returns the block to IDLE.
REQ-040 SHALL be tested with: IR=32'hFC00_0000 -> halted=1 after DECODE, no rf_we pulse, retired unchanged.
REQ-041 SHALL be tested with: RESET_PC=32'hFFFF_FFFC, one ALU instruction retired -> PC=0; also, an instruction with rd=0 and IR[5]=1 -> rf_we stays 0.
REQ-042 SHALL be tested with: RST asserted on the 2nd MULW cycle -> next cycle state=IDLE, PC=RESET_PC, retired=0, no rf_we pulse.
